// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first,
// using a single full-subtractor cell behind a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             a_bit;
  logic             b_bit;
  logic             d;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs plus result shift-in.
  always_comb begin
    a_bit    = a_sh[0];
    b_bit    = b_sh[0];
    d        = a_bit ^ b_bit ^ br;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    // Shift then overwrite the MSB so the expression stays legal for WIDTH=1.
    res_next            = res_sh >> 1;
    res_next[WIDTH-1]   = d;
    last_bit = (cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff <= res_next;
            bout <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
